// File: rtl/btn_db_defs.sv
// Shared definitions for the pushbutton debouncer: state encoding and default settle width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// The state codes are fixed so that debug taps and waveforms read the same across builds.
package btn_db_defs;

    localparam logic [1:0] ZERO  = 2'b00;
    localparam logic [1:0] WAIT1 = 2'b01;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] WAIT0 = 2'b11;

    // 2^20 cycles is about 10.5 ms at 100 MHz, which covers typical contact bounce.
    localparam int DEF_CNT_W = 20;

    typedef enum logic [1:0] {
        ST_ZERO  = ZERO,
        ST_WAIT1 = WAIT1,
        ST_ONE   = ONE,
        ST_WAIT0 = WAIT0
    } db_state_e;

endpackage

// File: rtl/btn_db_cell.sv
// Single-bit debouncer: 2-FF synchronizer, settle FSM with down-counter, registered level/edge pulses.
// Latency: level and tick change 2^CNT_W+3 edges after the pin changes and stays changed.
// Backpressure: none; outputs are free-running levels and pulses.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   btn      raw asynchronous pin
//   db_level debounced level
//   db_tick  one-cycle pulse on a debounced rising edge
//   db_fall  one-cycle pulse on a debounced falling edge (only with BTN_DB_FALL_TICK_EN)
module btn_db_cell
    import btn_db_defs::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db_level,
    output logic db_tick
`ifdef BTN_DB_FALL_TICK_EN
    ,
    output logic db_fall
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync_q1;
    logic             sync_q2;
    logic             s;
    db_state_e        state;
    db_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_zero;

    // Two-flop synchronizer; everything downstream sees only s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    assign s        = sync_q2;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_ZERO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter only decrements while nonzero, so it never wraps; each new
    // attempt reloads it to all-ones and therefore restarts the full window.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_ZERO: begin
                if (s) begin
                    state_nxt = ST_WAIT1;
                    cnt_nxt   = '1;
                end
            end
            ST_WAIT1: begin
                if (!s) begin
                    state_nxt = ST_ZERO;
                end else if (!cnt_zero) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (!s) begin
                    state_nxt = ST_WAIT0;
                    cnt_nxt   = '1;
                end
            end
            ST_WAIT0: begin
                if (s) begin
                    state_nxt = ST_ONE;
                end else if (!cnt_zero) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    state_nxt = ST_ZERO;
                end
            end
            default: begin
                state_nxt = ST_ZERO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register: level is high in the same cycle the state is ONE/WAIT0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            db_level <= (state_nxt == ST_ONE) || (state_nxt == ST_WAIT0);
            db_tick  <= (state == ST_WAIT1) && (state_nxt == ST_ONE);
        end
    end

`ifdef BTN_DB_FALL_TICK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_fall <= 1'b0;
        end else begin
            db_fall <= (state == ST_WAIT0) && (state_nxt == ST_ZERO);
        end
    end
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-button debouncer: N independent cells producing clean levels and press pulses.
// Latency: 2^CNT_W+3 edges from a stable pin change to the level/pulse output.
// Backpressure: none; outputs are free-running levels and pulses.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   btn      raw asynchronous button pins, active-high
//   db_level debounced levels
//   db_tick  one-cycle pulses on debounced rising edges
//   db_fall  one-cycle pulses on debounced falling edges (only with BTN_DB_FALL_TICK_EN)
// Optional feature macro: BTN_DB_FALL_TICK_EN adds the db_fall port and its logic.
module btn_debounce
    import btn_db_defs::*;
#(
    parameter int N     = 2,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn,
    output logic [N-1:0] db_level,
    output logic [N-1:0] db_tick
`ifdef BTN_DB_FALL_TICK_EN
    ,
    output logic [N-1:0] db_fall
`endif
);

    for (genvar i = 0; i < N; i++) begin : g_cell
        btn_db_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .btn      (btn[i]),
            .db_level (db_level[i]),
            .db_tick  (db_tick[i])
`ifdef BTN_DB_FALL_TICK_EN
            ,
            .db_fall  (db_fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with N=2, CNT_W=4.
// Reference model: each bit's debounced level flips once the synchronized input
// has disagreed with it for 2^CNT_W+1 consecutive edges.
module tb_btn_debounce;

    localparam int N      = 2;
    localparam int CNT_W  = 4;
    localparam int STABLE = (1 << CNT_W) + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn = '0;
    logic [N-1:0] db_level;
    logic [N-1:0] db_tick;
`ifdef BTN_DB_FALL_TICK_EN
    logic [N-1:0] db_fall;
`endif

    int tests = 0;
    int fails = 0;
    int tick0_cnt = 0;
    int fall0_cnt = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .db_level (db_level),
        .db_tick  (db_tick)
`ifdef BTN_DB_FALL_TICK_EN
        ,
        .db_fall  (db_fall)
`endif
    );

    // ---------------- reference model ----------------
    logic [N-1:0] m_d1 = '0;
    logic [N-1:0] m_d2 = '0;
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_tick = '0;
    logic [N-1:0] m_fall = '0;
    int           m_run [N];
    int           m_run_nxt [N];
    logic [N-1:0] m_level_nxt;
    logic [N-1:0] m_tick_nxt;
    logic [N-1:0] m_fall_nxt;

    // m_d2 is the pin value two edges ago: what the debouncer judges at this edge.
    always_comb begin
        m_level_nxt = m_level;
        m_tick_nxt  = '0;
        m_fall_nxt  = '0;
        for (int i = 0; i < N; i++) begin
            m_run_nxt[i] = 0;
            if (m_d2[i] != m_level[i]) begin
                if (m_run[i] + 1 == STABLE) begin
                    m_level_nxt[i] = m_d2[i];
                    m_tick_nxt[i]  = m_d2[i];
                    m_fall_nxt[i]  = ~m_d2[i];
                end else begin
                    m_run_nxt[i] = m_run[i] + 1;
                end
            end
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d1    <= '0;
            m_d2    <= '0;
            m_level <= '0;
            m_tick  <= '0;
            m_fall  <= '0;
            for (int i = 0; i < N; i++) m_run[i] <= 0;
        end else begin
            m_d1    <= btn;
            m_d2    <= m_d1;
            m_level <= m_level_nxt;
            m_tick  <= m_tick_nxt;
            m_fall  <= m_fall_nxt;
            for (int i = 0; i < N; i++) m_run[i] <= m_run_nxt[i];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) m_run[i] = 0;
        reset = 1'b1;
        #1 reset = 1'b0;

        fork
            forever begin
                @(negedge clk);
                check("model_level", db_level, m_level);
                check("model_tick", db_tick, m_tick);
`ifdef BTN_DB_FALL_TICK_EN
                check("model_fall", db_fall, m_fall);
                fall0_cnt += int'(db_fall[0]);
`endif
                tick0_cnt += int'(db_tick[0]);
            end
        join_none

        // Reset held with both buttons pressed.
        btn = 2'b11;
        step(3);
        check("rst_level", db_level, 2'b00);
        check("rst_tick", db_tick, 2'b00);
        reset = 1'b1;
        step(18);
        check("rel_level_e18", db_level, 2'b00);
        step(1);
        check("rel_level_e19", db_level, 2'b11);
        check("rel_tick_e19", db_tick, 2'b11);
        step(1);
        check("rel_tick_e20", db_tick, 2'b00);
        check("rel_level_e20", db_level, 2'b11);

        // Release both and let them settle.
        btn = 2'b00;
        step(40);
        check("idle_level", db_level, 2'b00);

        // Clean press on bit 0.
        btn = 2'b01;
        step(18);
        check("press_level_e18", db_level, 2'b00);
        step(1);
        check("press_level_e19", db_level, 2'b01);
        check("press_tick_e19", db_tick, 2'b01);
        step(1);
        check("press_tick_e20", db_tick, 2'b00);
        step(20);
        check("press_hold_level", db_level, 2'b01);

        // Release, then a bouncing press.
        btn = 2'b00;
        step(40);
        check("bounce_pre_level", db_level, 2'b00);
        tick0_cnt = 0;
        repeat (4) begin
            btn[0] = 1'b1;
            step(5);
            btn[0] = 1'b0;
            step(3);
        end
        btn[0] = 1'b1;
        step(18);
        check("bounce_level_e18", db_level, 2'b00);
        check_int("bounce_no_early_tick", tick0_cnt, 0);
        step(1);
        check("bounce_level_e19", db_level, 2'b01);
        check("bounce_tick_e19", db_tick, 2'b01);
        step(10);
        check_int("bounce_tick_count", tick0_cnt, 1);

        // Release glitch shorter than the settle window.
        fall0_cnt = 0;
        btn[0] = 1'b0;
        step(10);
        btn[0] = 1'b1;
        step(30);
        check("glitch_level", db_level, 2'b01);
        check_int("glitch_no_tick", tick0_cnt, 1);
        check_int("glitch_no_fall", fall0_cnt, 0);

        // Reset in the middle of a settle window on bit 1.
        btn = 2'b11;
        step(10);
        #2 reset = 1'b0;
        #1;
        check("midrst_level", db_level, 2'b00);
        check("midrst_tick", db_tick, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        step(18);
        check("midrst_level_e18", db_level, 2'b00);
        step(1);
        check("midrst_level_e19", db_level, 2'b11);
        check("midrst_tick_e19", db_tick, 2'b11);

        // Held release: level drops 19 edges later.
        step(5);
        btn = 2'b00;
        step(18);
        check("rel0_level_e18", db_level, 2'b11);
`ifdef BTN_DB_FALL_TICK_EN
        check("rel0_fall_e18", db_fall, 2'b00);
`endif
        step(1);
        check("rel0_level_e19", db_level, 2'b00);
`ifdef BTN_DB_FALL_TICK_EN
        check("rel0_fall_e19", db_fall, 2'b11);
`endif
        step(1);
        check("rel0_tick_e20", db_tick, 2'b00);
`ifdef BTN_DB_FALL_TICK_EN
        check("rel0_fall_e20", db_fall, 2'b00);
`endif
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
